// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - pixel-write arbiter: per-source pending slots feeding one registered VGA write port (PLOT_ARB_RR_EN selects round-robin)
module plot_arbiter #(
    parameter int NUM_SRC  = 3,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC*X_W-1:0]       src_x,
    input  logic [NUM_SRC*Y_W-1:0]       src_y,
    input  logic [NUM_SRC*COLOUR_W-1:0]  src_colour,
    input  logic                         hold,
    input  logic                         ovf_clr,
    output logic [NUM_SRC-1:0]           pending,
    output logic [NUM_SRC-1:0]           overflow,
    output logic [NUM_SRC-1:0]           grant,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [X_W-1:0]      slot_x      [NUM_SRC];
    logic [Y_W-1:0]      slot_y      [NUM_SRC];
    logic [COLOUR_W-1:0] slot_colour [NUM_SRC];

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_SRC-1:0] issue_vec;
    logic [NUM_SRC-1:0] capture;
    logic [NUM_SRC-1:0] drop;

`ifdef PLOT_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Round-robin pick: first pending slot after the last granted source; hold masks the winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!win_valid && pending[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        if (hold) begin
            win_valid = 1'b0;
        end
    end

    // Pointer remembers the last issued source; it moves only when a write is issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= IDX_W'(NUM_SRC - 1);
        end else if (win_valid) begin
            rr_ptr <= win_idx;
        end
    end
`else
    // Fixed priority pick: lowest pending index wins so the clear source always goes first.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        if (hold) begin
            win_valid = 1'b0;
        end
    end
`endif

    // A slot accepts a new pixel when empty or when it is being drained on this edge; otherwise the request is dropped.
    always_comb begin
        issue_vec = '0;
        if (win_valid) begin
            issue_vec[win_idx] = 1'b1;
        end
        capture = src_req & (~pending | issue_vec);
        drop    = src_req & pending & ~issue_vec;
    end

    // Slot data registers load the requesting source's pixel on capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_x[i]      <= '0;
                slot_y[i]      <= '0;
                slot_colour[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (capture[i]) begin
                    slot_x[i]      <= src_x[i*X_W +: X_W];
                    slot_y[i]      <= src_y[i*Y_W +: Y_W];
                    slot_colour[i] <= src_colour[i*COLOUR_W +: COLOUR_W];
                end
            end
        end
    end

    // Pending is set by capture and cleared by issue; overflow is sticky and a same-cycle drop beats ovf_clr.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= capture | (pending & ~issue_vec);
            overflow <= drop | (ovf_clr ? '0 : overflow);
        end
    end

    // Registered write port: the winner's slot goes out with a one-cycle plot/grant; coordinates hold when idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant  <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            grant <= issue_vec;
            plot  <= win_valid;
            if (win_valid) begin
                x      <= slot_x[win_idx];
                y      <= slot_y[win_idx];
                colour <= slot_colour[win_idx];
            end
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - scoreboard bench for plot_arbiter
module tb_plot_arbiter;

    logic        clk;
    logic        resetn;
    logic [2:0]  src_req;
    logic [23:0] src_x;
    logic [20:0] src_y;
    logic [8:0]  src_colour;
    logic        hold;
    logic        ovf_clr;
    logic [2:0]  pending;
    logic [2:0]  overflow;
    logic [2:0]  grant;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // {grant, x, y, colour}
    logic [20:0] sb [$];

    plot_arbiter #(.NUM_SRC(3), .X_W(8), .Y_W(7), .COLOUR_W(3)) dut (
        .clk(clk), .resetn(resetn), .src_req(src_req), .src_x(src_x), .src_y(src_y),
        .src_colour(src_colour), .hold(hold), .ovf_clr(ovf_clr), .pending(pending),
        .overflow(overflow), .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard comparator: every write on the port must match the oldest expected pixel.
    always @(negedge clk) begin
        logic [20:0] exp_w;
        if (resetn && mon_en) begin
            if (plot) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_write got grant=%b x=%h y=%h colour=%h required none", grant, x, y, colour);
                end else begin
                    exp_w = sb.pop_front();
                    if ({grant, x, y, colour} !== exp_w) begin
                        bad++;
                        $display("FAIL sb_write got %h required %h", {grant, x, y, colour}, exp_w);
                    end
                end
            end else if (grant !== 3'b000) begin
                total++;
                bad++;
                $display("FAIL grant_without_plot got %b required 000", grant);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
        src_x[i*8 +: 8]      = xv;
        src_y[i*7 +: 7]      = yv;
        src_colour[i*3 +: 3] = cv;
    endtask

    task automatic push_exp(input logic [2:0] g, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
        sb.push_back({g, xv, yv, cv});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain_timeout got %0d left required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; src_req = '0; src_x = '0; src_y = '0; src_colour = '0;
        hold = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (pending !== 3'b000)  begin bad++; $display("FAIL reset_pending got %b required 000", pending); end
        total++; if (overflow !== 3'b000) begin bad++; $display("FAIL reset_overflow got %b required 000", overflow); end
        total++; if (grant !== 3'b000)    begin bad++; $display("FAIL reset_grant got %b required 000", grant); end
        total++; if (plot !== 1'b0)       begin bad++; $display("FAIL reset_plot got %b required 0", plot); end
        total++; if ({x, y, colour} !== 18'd0) begin bad++; $display("FAIL reset_xyc got %h required 0", {x, y, colour}); end
        resetn = 1'b1;
        cycle();
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL release_plot got %b required 0", plot); end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        set_src(1, 8'h2A, 7'h10, 3'd3);
        src_req = 3'b010;
        push_exp(3'b010, 8'h2A, 7'h10, 3'd3);
        cycle();
        src_req = 3'b000;
        total++; if (pending !== 3'b010) begin bad++; $display("FAIL single_pending got %b required 010", pending); end
        cycle();
        total++; if (plot !== 1'b1 || grant !== 3'b010) begin bad++; $display("FAIL single_issue got plot=%b grant=%b required 1/010", plot, grant); end
        cycle();
        total++; if (plot !== 1'b0 || pending !== 3'b000) begin bad++; $display("FAIL single_after got plot=%b pending=%b required 0/000", plot, pending); end
        total++; if ({x, y, colour} !== {8'h2A, 7'h10, 3'd3}) begin bad++; $display("FAIL single_hold_xyc got %h required %h", {x, y, colour}, {8'h2A, 7'h10, 3'd3}); end
        drain("single");
    endtask

    task automatic test_simultaneous();
        set_src(0, 8'h00, 7'h01, 3'd0);
        set_src(1, 8'h55, 7'h22, 3'd5);
        set_src(2, 8'hA0, 7'h7F, 3'd7);
        src_req = 3'b111;
        push_exp(3'b001, 8'h00, 7'h01, 3'd0);
        push_exp(3'b010, 8'h55, 7'h22, 3'd5);
        push_exp(3'b100, 8'hA0, 7'h7F, 3'd7);
        cycle();
        src_req = 3'b000;
        repeat (3) cycle();
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL simul_pending got %b required 000", pending); end
        total++; if (overflow !== 3'b000) begin bad++; $display("FAIL simul_overflow got %b required 000", overflow); end
        drain("simul");
    endtask

    task automatic test_overflow();
        hold = 1'b1;
        set_src(2, 8'h11, 7'h22, 3'd5);
        src_req = 3'b100;
        push_exp(3'b100, 8'h11, 7'h22, 3'd5);
        cycle();
        set_src(2, 8'h33, 7'h44, 3'd6);
        cycle();
        src_req = 3'b000;
        total++; if (overflow !== 3'b100) begin bad++; $display("FAIL ovf_flag got %b required 100", overflow); end
        total++; if (plot !== 1'b0 || pending !== 3'b100) begin bad++; $display("FAIL ovf_hold got plot=%b pending=%b required 0/100", plot, pending); end
        cycle();
        total++; if (plot !== 1'b0) begin bad++; $display("FAIL ovf_hold_plot got %b required 0", plot); end
        hold = 1'b0;
        drain("ovf");
        total++; if (overflow !== 3'b100) begin bad++; $display("FAIL ovf_sticky got %b required 100", overflow); end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        total++; if (overflow !== 3'b000) begin bad++; $display("FAIL ovf_clr got %b required 000", overflow); end
    endtask

    task automatic test_refill();
        for (int k = 0; k < 8; k++) begin
            set_src(1, 8'(8'h40 + k), 7'(k * 3), 3'(k));
            src_req = 3'b010;
            push_exp(3'b010, 8'(8'h40 + k), 7'(k * 3), 3'(k));
            cycle();
            if (k > 0) begin
                total++; if (plot !== 1'b1) begin bad++; $display("FAIL refill_plot_%0d got %b required 1", k, plot); end
            end
        end
        src_req = 3'b000;
        cycle();
        total++; if (plot !== 1'b1) begin bad++; $display("FAIL refill_plot_last got %b required 1", plot); end
        total++; if (overflow !== 3'b000) begin bad++; $display("FAIL refill_overflow got %b required 000", overflow); end
        drain("refill");
    endtask

    task automatic test_contention();
        set_src(1, 8'h01, 7'h01, 3'd1);
        set_src(2, 8'h02, 7'h02, 3'd2);
`ifdef PLOT_ARB_RR_EN
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 0) push_exp(3'b010, 8'h01, 7'h01, 3'd1);
            else            push_exp(3'b100, 8'h02, 7'h02, 3'd2);
        end
`else
        for (int k = 0; k < 6; k++) push_exp(3'b010, 8'h01, 7'h01, 3'd1);
        push_exp(3'b100, 8'h02, 7'h02, 3'd2);
`endif
        src_req = 3'b110;
        repeat (6) cycle();
        src_req = 3'b000;
        drain("contend");
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL contend_pending got %b required 000", pending); end
`ifndef PLOT_ARB_RR_EN
        total++; if (overflow !== 3'b100) begin bad++; $display("FAIL contend_overflow got %b required 100", overflow); end
`endif
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        mon_en = 1'b0;
        set_src(0, 8'h77, 7'h33, 3'd4);
        set_src(1, 8'h66, 7'h22, 3'd2);
        set_src(2, 8'h55, 7'h11, 3'd1);
        src_req = 3'b111;
        cycle();
        src_req = 3'b000;
        cycle();
        total++; if (plot !== 1'b1) begin bad++; $display("FAIL areset_pre_plot got %b required 1", plot); end
        #2;
        resetn = 1'b0;
        #1;
        total++; if (plot !== 1'b0 || grant !== 3'b000) begin bad++; $display("FAIL areset_port got plot=%b grant=%b required 0/000", plot, grant); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL areset_pending got %b required 000", pending); end
        total++; if ({x, y, colour} !== 18'd0) begin bad++; $display("FAIL areset_xyc got %h required 0", {x, y, colour}); end
        @(posedge clk);
        #3;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            total++; if (plot !== 1'b0) begin bad++; $display("FAIL areset_release_%0d got plot=%b required 0", k, plot); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_refill();
        test_contention();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
